// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver; frames start/data/parity/stop and
// strobes one word per good frame into the RX FIFO, pulsing error flags.
// Ports:
//   clk_i, reset_i     clock, async active-high reset
//   rx_i               async serial line, idles high
//   baud_tick_i        OVERSAMPLE x baud enable
//   par_en_i/par_odd_i parity enable / odd select, latched at start detect
//   rdata_o, wen_o     received word and 1-cycle FIFO write strobe
//   par_err_o          parity failure, coincident with wen_o
//   frame_err_o        stop bit sampled low
//   break_o            all-zero frame, coincident with frame_err_o
//   busy_o             FSM not idle
module uart_rx #(
   parameter int DATA_W      = 8,
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              rx_i,
   input  logic              baud_tick_i,
   input  logic              par_en_i,
   input  logic              par_odd_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              wen_o,
   output logic              par_err_o,
   output logic              frame_err_o,
   output logic              break_o,
   output logic              busy_o
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_W + 1);

   localparam logic [TW-1:0] TMID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TEND  = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BLAST = BW'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HI
   } state_t;

   state_t state, state_n;

   logic [SYNC_STAGES-1:0] sync;
   logic                   rx_s;

   logic [TW-1:0]     tick_cnt, tick_n;
   logic [BW-1:0]     bit_cnt, bit_n;
   logic [DATA_W-1:0] shreg, shreg_n;
   logic [DATA_W-1:0] rdata_n;
   logic              pen, pen_n;
   logic              podd, podd_n;
   logic              perr, perr_n;
   logic              pbit, pbit_n;
   logic              wen_n, par_err_n, ferr_n, brk_n;
   logic              mid, centre;

   assign rx_s   = sync[SYNC_STAGES-1];
   assign mid    = (tick_cnt == TMID);
   assign centre = (tick_cnt == TEND);
   assign busy_o = (state != IDLE);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         sync        <= '1;
         state       <= IDLE;
         tick_cnt    <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         pen         <= 1'b0;
         podd        <= 1'b0;
         perr        <= 1'b0;
         pbit        <= 1'b0;
         rdata_o     <= '0;
         wen_o       <= 1'b0;
         par_err_o   <= 1'b0;
         frame_err_o <= 1'b0;
         break_o     <= 1'b0;
      end else begin
         sync        <= {sync[SYNC_STAGES-2:0], rx_i};
         state       <= state_n;
         tick_cnt    <= tick_n;
         bit_cnt     <= bit_n;
         shreg       <= shreg_n;
         pen         <= pen_n;
         podd        <= podd_n;
         perr        <= perr_n;
         pbit        <= pbit_n;
         rdata_o     <= rdata_n;
         wen_o       <= wen_n;
         par_err_o   <= par_err_n;
         frame_err_o <= ferr_n;
         break_o     <= brk_n;
      end
   end

   always_comb begin
      state_n   = state;
      tick_n    = tick_cnt;
      bit_n     = bit_cnt;
      shreg_n   = shreg;
      pen_n     = pen;
      podd_n    = podd;
      perr_n    = perr;
      pbit_n    = pbit;
      rdata_n   = rdata_o;
      wen_n     = 1'b0;
      par_err_n = 1'b0;
      ferr_n    = 1'b0;
      brk_n     = 1'b0;
      if (baud_tick_i) begin
         unique case (state)
            IDLE: begin
               if (!rx_s) begin
                  state_n = START;
                  tick_n  = '0;
                  pen_n   = par_en_i;
                  podd_n  = par_odd_i;
                  perr_n  = 1'b0;
                  pbit_n  = 1'b0;
               end
            end
            START: begin
               if (mid) begin
                  tick_n = '0;
                  bit_n  = '0;
                  // a start bit gone high by mid-bit is line noise
                  state_n = rx_s ? IDLE : DATA;
               end else begin
                  tick_n = tick_cnt + 1'b1;
               end
            end
            DATA: begin
               if (centre) begin
                  tick_n  = '0;
                  shreg_n = {rx_s, shreg[DATA_W-1:1]};
                  bit_n   = bit_cnt + 1'b1;
                  if (bit_cnt == BLAST)
                     state_n = pen ? PARITY : STOP;
               end else begin
                  tick_n = tick_cnt + 1'b1;
               end
            end
            PARITY: begin
               if (centre) begin
                  tick_n  = '0;
                  pbit_n  = rx_s;
                  perr_n  = ((^shreg) ^ rx_s) != podd;
                  state_n = STOP;
               end else begin
                  tick_n = tick_cnt + 1'b1;
               end
            end
            STOP: begin
               if (centre) begin
                  tick_n = '0;
                  if (rx_s) begin
                     state_n   = IDLE;
                     wen_n     = 1'b1;
                     rdata_n   = shreg;
                     par_err_n = perr;
                  end else begin
                     // stay out of IDLE so a held break cannot restart
                     state_n = WAIT_HI;
                     ferr_n  = 1'b1;
                     brk_n   = (shreg == '0) && !pbit;
                  end
               end else begin
                  tick_n = tick_cnt + 1'b1;
               end
            end
            WAIT_HI: begin
               if (rx_s)
                  state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames into uart_rx and compares the strobes
// it produces with a frame-level model of the receiver.
module tb_uart_rx;

   localparam int BIT = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic       tick = 1'b0;
   logic       par_en = 1'b0;
   logic       par_odd = 1'b0;
   logic [7:0] rdata;
   logic       wen, perr, ferr, brk, busy;

   int total = 0;
   int bad = 0;
   int tcnt = 0;

   typedef struct {
      int         kind;
      logic [7:0] data;
      logic       perr;
      logic       brk;
   } ev_t;

   ev_t obs[$];
   ev_t exp_q[$];

   uart_rx #(
      .DATA_W(8),
      .OVERSAMPLE(16),
      .SYNC_STAGES(2)
   ) dut (
      .clk_i(clk),
      .reset_i(rst),
      .rx_i(rx),
      .baud_tick_i(tick),
      .par_en_i(par_en),
      .par_odd_i(par_odd),
      .rdata_o(rdata),
      .wen_o(wen),
      .par_err_o(perr),
      .frame_err_o(ferr),
      .break_o(brk),
      .busy_o(busy)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(negedge clk);
      tick = (tcnt % 4 == 3);
      tcnt = tcnt + 1;
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (wen && !ferr)
            obs.push_back('{kind: 0, data: rdata, perr: perr, brk: brk});
         else if (ferr && !wen)
            obs.push_back('{kind: 1, data: 8'h00, perr: perr, brk: brk});
         else if (wen || ferr || perr || brk)
            obs.push_back('{kind: 2, data: rdata, perr: perr, brk: brk});
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (BIT) @(negedge clk);
   endtask

   task automatic idle(input int bits);
      rx = 1'b1;
      repeat (bits * BIT) @(negedge clk);
   endtask

   // frame-level expectation: stop high writes a word, stop low is a framing error
   task automatic model(input logic [7:0] d, input logic pe, input logic po,
                        input logic pb, input logic st);
      int ones;
      logic odd_total;
      ones = $countones(d) + int'(pb);
      odd_total = (ones % 2) == 1;
      if (st)
         exp_q.push_back('{kind: 0, data: d,
                           perr: pe && (odd_total != po), brk: 1'b0});
      else
         exp_q.push_back('{kind: 1, data: 8'h00, perr: 1'b0,
                           brk: (d == 8'h00) && !(pe && pb)});
   endtask

   task automatic send(input logic [7:0] d, input logic pe, input logic po,
                       input logic pb, input logic st, input bit scr = 0);
      par_en = pe;
      par_odd = po;
      model(d, pe, po, pb, st);
      drive_bit(1'b0);
      if (scr) begin
         par_en = 1'($urandom_range(0, 1));
         par_odd = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < 8; i++)
         drive_bit(d[i]);
      if (pe)
         drive_bit(pb);
      drive_bit(st);
      rx = 1'b1;
   endtask

   task automatic compare(input string tag);
      chk({tag, "_count"}, 32'(obs.size()), 32'(exp_q.size()));
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
         chk({tag, "_kind"}, 32'(obs[i].kind), 32'(exp_q[i].kind));
         chk({tag, "_data"}, 32'(obs[i].data), 32'(exp_q[i].data));
         chk({tag, "_perr"}, 32'(obs[i].perr), 32'(exp_q[i].perr));
         chk({tag, "_brk"}, 32'(obs[i].brk), 32'(exp_q[i].brk));
      end
      obs.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [7:0] d;
      logic pe, po, pb, st;
      repeat (5) @(negedge clk);
      chk("rst_wen", 32'(wen), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      chk("rst_ferr", 32'(ferr), 32'd0);
      chk("rst_brk", 32'(brk), 32'd0);
      chk("rst_perr", 32'(perr), 32'd0);
      rst = 1'b0;
      idle(1);

      send(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
      send(8'hA3, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(2);
      compare("b2b");

      send(8'hA3, 1'b1, 1'b0, 1'b1, 1'b1);
      send(8'hA3, 1'b1, 1'b0, 1'b0, 1'b1);
      send(8'h5B, 1'b1, 1'b1, 1'b0, 1'b1);
      idle(2);
      compare("parity");

      send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1);
      send(8'h12, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(2);
      compare("frame");

      rx = 1'b0;
      repeat (16) @(negedge clk);
      rx = 1'b1;
      repeat (32) @(negedge clk);
      chk("glitch_busy", 32'(busy), 32'd0);
      idle(1);
      send(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(2);
      compare("glitch");

      exp_q.push_back('{kind: 1, data: 8'h00, perr: 1'b0, brk: 1'b1});
      rx = 1'b0;
      repeat (20 * BIT) @(negedge clk);
      chk("break_busy_low", 32'(busy), 32'd1);
      idle(1);
      chk("break_busy_high", 32'(busy), 32'd0);
      send(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(2);
      compare("break");

      par_en = 1'b0;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++)
         drive_bit(1'b1);
      rx = 1'b1;
      repeat (BIT / 2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_wen", 32'(wen), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_rdata", 32'(rdata), 32'd0);
      chk("mid_rst_ferr", 32'(ferr), 32'd0);
      repeat (4) @(negedge clk);
      rst = 1'b0;
      idle(2);
      send(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(2);
      chk("after_rst_rdata", 32'(rdata), 32'h0F);
      compare("reset");

      for (int n = 0; n < 40; n++) begin
         d = 8'($urandom);
         if (n % 10 == 0)
            d = 8'h00;
         pe = 1'($urandom_range(0, 1));
         po = 1'($urandom_range(0, 1));
         pb = 1'($urandom_range(0, 1));
         st = ($urandom_range(0, 5) != 0);
         send(d, pe, po, pb, st, 1);
         if (!st)
            idle(1 + $urandom_range(0, 1));
         else
            idle($urandom_range(0, 2));
      end
      idle(2);
      compare("random");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
